// File: rtl/rv_reg_file.sv
// rv_reg_file: 31 x XLEN integer register file, x0 hard-wired to zero.
// Two combinational read ports (a1/rd1, a2/rd2) and one clocked write port (we3/a3/wd3).
// Ports: clk, rst_n (async, active-low); we3, a1, a2, a3 [4:0], wd3 [XLEN-1:0];
//        rd1, rd2 [XLEN-1:0].
// Build option: define REG_FILE_BYPASS_EN to forward wd3 to a read port
//   whose address matches a3 in the write cycle. Without it, a read returns the old value.
module rv_reg_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we3,
  input  logic [4:0]      a1,
  input  logic [4:0]      a2,
  input  logic [4:0]      a3,
  input  logic [XLEN-1:0] wd3,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] r_regs [1:NREG-1];
  logic            w_wr;
  logic [XLEN-1:0] w_rd1;
  logic [XLEN-1:0] w_rd2;

  // A write to x0 is dropped here, so x0 never needs storage.
  assign w_wr = we3 && (a3 != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (w_wr && (a3 == 5'(i))) begin
          r_regs[i] <= wd3;
        end
      end
    end
  end

  // Address 0 (and any unmatched address) falls through to zero.
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    for (int i = 1; i < NREG; i++) begin
      if (a1 == 5'(i)) w_rd1 = r_regs[i];
      if (a2 == 5'(i)) w_rd2 = r_regs[i];
    end
  end

`ifdef REG_FILE_BYPASS_EN
  // Forwarding is masked in reset so reads stay zero while rst_n is low.
  logic w_fwd1;
  logic w_fwd2;

  assign w_fwd1 = rst_n && w_wr && (a1 == a3);
  assign w_fwd2 = rst_n && w_wr && (a2 == a3);
  assign rd1    = w_fwd1 ? wd3 : w_rd1;
  assign rd2    = w_fwd2 ? wd3 : w_rd2;
`else
  assign rd1 = w_rd1;
  assign rd2 = w_rd2;
`endif

endmodule

// File: tb/tb_rv_reg_file.sv
// tb_rv_reg_file: directed checks of rv_reg_file.
// Expected read data is queued by the stimulus and compared by a monitor.
module tb_rv_reg_file;

  logic        clk;
  logic        rst_n;
  logic        we3;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [31:0] rd1;
  logic [31:0] rd2;

  typedef struct {
    string       nm;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   total = 0;
  int   bad   = 0;

  rv_reg_file #(.XLEN(32), .NREG(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .we3  (we3),
    .a1   (a1),
    .a2   (a2),
    .a3   (a3),
    .wd3  (wd3),
    .rd1  (rd1),
    .rd2  (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: read data is valid 1 time unit after a sample request.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      #1;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL %s: no expectation queued", "monitor");
      end else begin
        e = q.pop_front();
        if (rd1 !== e.e1) begin
          bad++;
          $display("FAIL %s rd1: got %h want %h", e.nm, rd1, e.e1);
        end
        total++;
        if (rd2 !== e.e2) begin
          bad++;
          $display("FAIL %s rd2: got %h want %h", e.nm, rd2, e.e2);
        end
      end
    end
  end

  task automatic expect_rd(input string nm,
                           input logic [4:0] x1, input logic [4:0] x2,
                           input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    a1 = x1;
    a2 = x2;
    e.nm = nm;
    e.e1 = e1;
    e.e2 = e2;
    q.push_back(e);
    -> chk_ev;
    #2;
  endtask

  task automatic wr(input logic [4:0] adr, input logic [31:0] dat);
    @(negedge clk);
    we3 = 1'b1;
    a3  = adr;
    wd3 = dat;
    @(posedge clk);
    #1;
    we3 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hz;
`ifdef REG_FILE_BYPASS_EN
    hz = 32'h0000_CAFE;
`else
    hz = 32'h0000_0000;
`endif
    rst_n = 1'b0;
    we3   = 1'b0;
    a1    = 5'd0;
    a2    = 5'd0;
    a3    = 5'd0;
    wd3   = 32'h0;
    #1;
    expect_rd("reset_0_31", 5'd0, 5'd31, 32'h0, 32'h0);
    expect_rd("reset_5_9", 5'd5, 5'd9, 32'h0, 32'h0);

    // Write attempt while in reset: ignored, not forwarded.
    @(negedge clk);
    we3 = 1'b1;
    a3  = 5'd9;
    wd3 = 32'h9999_9999;
    expect_rd("rst_wr_fwd", 5'd9, 5'd9, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    we3 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    expect_rd("rst_wr_drop", 5'd9, 5'd0, 32'h0, 32'h0);

    wr(5'd3, 32'h1234_5678);
    expect_rd("wr_x3", 5'd3, 5'd3, 32'h1234_5678, 32'h1234_5678);

    wr(5'd0, 32'hFFFF_FFFF);
    expect_rd("wr_x0", 5'd0, 5'd0, 32'h0, 32'h0);

    wr(5'd7, 32'hA5A5_A5A5);
    @(negedge clk);
    we3 = 1'b0;
    a3  = 5'd7;
    wd3 = 32'h0;
    @(posedge clk);
    #1;
    expect_rd("we_off_x7", 5'd3, 5'd7, 32'h1234_5678, 32'hA5A5_A5A5);

    wr(5'd1, 32'h0000_0011);
    wr(5'd31, 32'h3131_3131);
    expect_rd("dual_1_31", 5'd1, 5'd31, 32'h0000_0011, 32'h3131_3131);

    // x0 is never forwarded.
    @(negedge clk);
    we3 = 1'b1;
    a3  = 5'd0;
    wd3 = 32'h0000_BEEF;
    expect_rd("x0_nofwd", 5'd0, 5'd0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    we3 = 1'b0;

    wr(5'd4, 32'h0);
    @(negedge clk);
    we3 = 1'b1;
    a3  = 5'd4;
    wd3 = 32'h0000_CAFE;
    expect_rd("hazard_pre", 5'd4, 5'd3, hz, 32'h1234_5678);
    @(posedge clk);
    #1;
    we3 = 1'b0;
    expect_rd("hazard_post", 5'd4, 5'd4, 32'h0000_CAFE, 32'h0000_CAFE);
    expect_rd("hold_3_7", 5'd3, 5'd7, 32'h1234_5678, 32'hA5A5_A5A5);
    expect_rd("hold_1_31", 5'd1, 5'd31, 32'h0000_0011, 32'h3131_3131);

    wr(5'd5, 32'hDEAD_BEEF);
    expect_rd("wr_x5", 5'd5, 5'd4, 32'hDEAD_BEEF, 32'h0000_CAFE);
    // Async reset mid-cycle: cleared before the next clock edge.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    expect_rd("async_rst", 5'd5, 5'd31, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_rd("post_rst", 5'd3, 5'd7, 32'h0, 32'h0);
    wr(5'd5, 32'h0000_0001);
    expect_rd("first_wr", 5'd5, 5'd1, 32'h0000_0001, 32'h0);

    #5;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d left want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
